// File: rtl/computer_mc.sv
// computer_mc: multicycle accumulator-style core with two registers (A, B),
// an ALU, an internal data memory, {N,Z,C} flags, conditional jumps, halt
// and a run/stall input. Instructions come from an external asynchronous
// instruction memory; every instruction takes one FETCH and one EXEC cycle.
//
// Instruction word: {op[7:0], literal[DATA_W-1:0]}
//   op[7:5] class, op[4:3] source select, op[2:0] ALU function / jump condition
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   run        in   1 lets FETCH advance, 0 holds the core in FETCH
//   imem_addr  out  instruction address (the PC)
//   imem_data  in   instruction word, valid in the same cycle
//   regA_out   out  register A
//   regB_out   out  register B
//   alu_out    out  ALU result of the instruction in EXEC, 0 otherwise
//   flags_out  out  {N,Z,C}
//   retire     out  one-cycle pulse in the cycle after each EXEC
//   halted     out  core is in HALT
//   fault      out  return-stack error latched (0 without the stack option)
//
// Build option: define CALL_STACK_EN to turn jump fn 5/6 into CALL/RET
// with a STACK_DEPTH-entry return stack. Without it they execute as NOPs.
//
// state  | meaning
// FETCH  | latch imem_data into IR when run=1, otherwise hold everything
// EXEC   | execute IR, update PC, pulse retire next cycle
// HALT   | HLT executed or stack fault; stays here until reset

module computer_mc #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DM_DEPTH    = 256,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [8+DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0]   regA_out,
  output logic [DATA_W-1:0]   regB_out,
  output logic [DATA_W-1:0]   alu_out,
  output logic [2:0]          flags_out,
  output logic                retire,
  output logic                halted,
  output logic                fault
);

  localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  if (DATA_W < 4) begin : g_chk_data_w
    $error("computer_mc: DATA_W must be at least 4");
  end
  if (ADDR_W > DATA_W) begin : g_chk_addr_w
    $error("computer_mc: ADDR_W must not exceed DATA_W");
  end
  if (STACK_DEPTH < 1) begin : g_chk_stack
    $error("computer_mc: STACK_DEPTH must be at least 1");
  end

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]          flags_q, flags_d;  // {N,Z,C}
  logic [8+DATA_W-1:0] ir_q, ir_d;
  logic                retire_q, retire_d;

  logic [DATA_W-1:0]   dm_q [DM_DEPTH];
  logic                dm_we;
  logic [DM_AW-1:0]    dm_waddr;
  logic [DATA_W-1:0]   dm_wdata;

  // DM address is the operand modulo DM_DEPTH (also correct for non power-of-2 depths)
  function automatic logic [DM_AW-1:0] dm_index(input logic [DATA_W-1:0] v);
    return DM_AW'(32'(v) % 32'(DM_DEPTH));
  endfunction

  logic [2:0]        cls, fn;
  logic [1:0]        src;
  logic [DATA_W-1:0] lit;
  logic [ADDR_W-1:0] target;

  assign cls    = ir_q[DATA_W+7:DATA_W+5];
  assign src    = ir_q[DATA_W+4:DATA_W+3];
  assign fn     = ir_q[DATA_W+2:DATA_W];
  assign lit    = ir_q[DATA_W-1:0];
  assign target = lit[ADDR_W-1:0];

  // Odd classes target B, even classes target A; "other reg" is the opposite one.
  logic [DATA_W-1:0] dst_val, other_val, src_val;
  assign dst_val   = cls[0] ? b_q : a_q;
  assign other_val = cls[0] ? a_q : b_q;

  always_comb begin
    src_val = other_val;
    case (src)
      2'b01:   src_val = lit;
      2'b10:   src_val = dm_q[dm_index(lit)];
      2'b11:   src_val = dm_q[dm_index(b_q)];
      default: src_val = other_val;
    endcase
  end

  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] res;
  logic              carry;

  assign sum_w = {1'b0, dst_val} + {1'b0, src_val};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    if (cls[1]) begin
      res = src_val;  // MOV: carry forced to 0
    end else begin
      case (fn)
        3'd0: begin res = sum_w[DATA_W-1:0]; carry = sum_w[DATA_W]; end
        3'd1: begin res = dst_val - src_val; carry = (dst_val < src_val); end
        3'd2: res = dst_val & src_val;
        3'd3: res = dst_val | src_val;
        3'd4: res = dst_val ^ src_val;
        3'd5: res = ~src_val;
        3'd6: begin res = {src_val[DATA_W-2:0], 1'b0}; carry = src_val[DATA_W-1]; end
        default: begin res = {1'b0, src_val[DATA_W-1:1]}; carry = src_val[0]; end
      endcase
    end
  end

  logic take;
  always_comb begin
    take = 1'b0;
    case (fn)
      3'd0:    take = 1'b1;
      3'd1:    take = flags_q[1];
      3'd2:    take = ~flags_q[1];
      3'd3:    take = flags_q[0];
      3'd4:    take = flags_q[2];
      default: take = 1'b0;
    endcase
  end

  assign dm_wdata = cls[0] ? b_q : a_q;
  assign dm_waddr = (src == 2'b01) ? dm_index(lit) : dm_index(b_q);

`ifdef CALL_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              fault_q, fault_d;
  logic              push;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    flags_d  = flags_q;
    ir_d     = ir_q;
    retire_d = 1'b0;
    dm_we    = 1'b0;
    alu_out  = '0;
`ifdef CALL_STACK_EN
    sp_d     = sp_q;
    fault_d  = fault_q;
    push     = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
        pc_d     = pc_q + 1'b1;
        case (cls)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            alu_out = res;
            if (cls[0]) b_d = res;
            else        a_d = res;
            flags_d = {res[DATA_W-1], (res == '0), carry};
          end
          3'b100, 3'b101: dm_we = 1'b1;
          3'b110: begin
            if (take) pc_d = target;
`ifdef CALL_STACK_EN
            if (fn == 3'd5) begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                pc_d    = pc_q;
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                push = 1'b1;
                sp_d = sp_q + 1'b1;
                pc_d = target;
              end
            end else if (fn == 3'd6) begin
              if (sp_q == '0) begin
                pc_d    = pc_q;
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                sp_d = sp_q - 1'b1;
                pc_d = stack_q[SI_W'(sp_q - 1'b1)];
              end
            end
`endif
          end
          default: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      ir_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      flags_q  <= flags_d;
      ir_q     <= ir_d;
      retire_q <= retire_d;
    end
  end

  // Data memory is never cleared; a reset edge blocks any pending store.
  always_ff @(posedge clk) begin
    if (rst_n && dm_we) dm_q[dm_waddr] <= dm_wdata;
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) stack_q[SI_W'(sp_q)] <= pc_q + 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign regA_out  = a_q;
  assign regB_out  = b_q;
  assign flags_out = flags_q;
  assign retire    = retire_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_computer_mc.sv
module tb_computer_mc;

  logic        clk;
  logic        rst_n, run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  regA_out, regB_out, alu_out;
  logic [2:0]  flags_out;
  logic        retire, halted, fault;

  logic [15:0] imem [256];
  logic        x_mode;

  assign imem_data = x_mode ? 16'hxxxx : imem[imem_addr];

  computer_mc #(.DATA_W(8), .ADDR_W(8), .DM_DEPTH(256), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .regA_out(regA_out), .regB_out(regB_out), .alu_out(alu_out),
    .flags_out(flags_out), .retire(retire), .halted(halted), .fault(fault)
  );

  // Second instance with a 4-bit PC to exercise wrap-around and reset-vs-store.
  logic        rst4_n, run4;
  logic [3:0]  imem4_addr;
  logic [15:0] imem4_data;
  logic [7:0]  a4, b4, alu4;
  logic [2:0]  f4;
  logic        ret4, halt4, fault4;
  logic [15:0] imem4 [16];

  assign imem4_data = imem4[imem4_addr];

  computer_mc #(.DATA_W(8), .ADDR_W(4), .DM_DEPTH(16), .STACK_DEPTH(2)) dut4 (
    .clk(clk), .rst_n(rst4_n), .run(run4),
    .imem_addr(imem4_addr), .imem_data(imem4_data),
    .regA_out(a4), .regB_out(b4), .alu_out(alu4),
    .flags_out(f4), .retire(ret4), .halted(halt4), .fault(fault4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ret = 0;

  // Monitor: every retire pulse is matched against the next expected state.
  always @(negedge clk) begin
    if (retire) begin
      n_ret++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: unexpected retire, got A=%h B=%h F=%b PC=%h, want no retire",
                 regA_out, regB_out, flags_out, imem_addr);
      end else begin
        e = sb.pop_front();
        if (regA_out !== e.a || regB_out !== e.b || flags_out !== e.f || imem_addr !== e.pc) begin
          n_err++;
          $display("FAIL retire_%0d: got A=%h B=%h F=%b PC=%h, want A=%h B=%h F=%b PC=%h",
                   n_ret, regA_out, regB_out, flags_out, imem_addr, e.a, e.b, e.f, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Place an instruction and queue the state expected right after it retires.
  task automatic ld(input logic [7:0] addr, input logic [7:0] op, input logic [7:0] lit,
                    input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] ef,
                    input logic [7:0] epc);
    exp_t x;
    imem[addr] = {op, lit};
    x.a = ea; x.b = eb; x.f = ef; x.pc = epc;
    sb.push_back(x);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset4();
    @(negedge clk);
    rst4_n = 1'b0;
    run4   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
  endtask

  // Run until HALT (bounded). Optionally stall 6 cycles after the stall_at-th retire.
  task automatic run_prog(input int stall_at, input int exp_edges,
                          input logic [7:0] spc, input logic [7:0] sa,
                          input logic [7:0] sbv, input logic [2:0] sf);
    int edges;
    int r;
    edges = 0;
    r     = 0;
    run   = 1'b1;
    while (!halted && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (retire) r++;
      if (stall_at != 0 && r == stall_at && retire) begin
        run = 1'b0;
        repeat (6) @(posedge clk);
        edges += 6;
        @(negedge clk);
        chk("stall_pc", 32'(imem_addr), 32'(spc));
        chk("stall_a", 32'(regA_out), 32'(sa));
        chk("stall_b", 32'(regB_out), 32'(sbv));
        chk("stall_flags", 32'(flags_out), 32'(sf));
        chk("stall_retire", 32'(retire), 32'd0);
        chk("stall_alu", 32'(alu_out), 32'd0);
        run = 1'b1;
      end
    end
    chk("halt_edges", 32'(edges), 32'(exp_edges));
    chk("halted", 32'(halted), 32'd1);
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    rst4_n = 1'b0;
    run4   = 1'b0;
    x_mode = 1'b1;
    clear_imem();
    for (int i = 0; i < 16; i++) imem4[i] = 16'hE000;

    // Reset with undefined instruction bus
    do_reset();
    chk("rst_pc", 32'(imem_addr), 32'd0);
    chk("rst_a", 32'(regA_out), 32'd0);
    chk("rst_b", 32'(regB_out), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_alu", 32'(alu_out), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    x_mode = 1'b0;

    // MOVA #5; ADD A,#3; STA [0x10]; MOVB [0x10]; HLT
    ld(8'h00, 8'h48, 8'h05, 8'h05, 8'h00, 3'b000, 8'h01);
    ld(8'h01, 8'h08, 8'h03, 8'h08, 8'h00, 3'b000, 8'h02);
    ld(8'h02, 8'h88, 8'h10, 8'h08, 8'h00, 3'b000, 8'h03);
    ld(8'h03, 8'h70, 8'h10, 8'h08, 8'h08, 3'b000, 8'h04);
    ld(8'h04, 8'hE0, 8'h00, 8'h08, 8'h08, 3'b000, 8'h04);
    chk("p1_ret_before", 32'(n_ret), 32'd0);
    run_prog(0, 10, 8'h00, 8'h00, 8'h00, 3'b000);
    repeat (2) @(negedge clk);
    chk("p1_retires", 32'(n_ret), 32'd5);
    chk("p1_hold_pc", 32'(imem_addr), 32'h04);

    // Same program with a 6-cycle stall after the store
    do_reset();
    chk("rst2_halted", 32'(halted), 32'd0);
    ld(8'h00, 8'h48, 8'h05, 8'h05, 8'h00, 3'b000, 8'h01);
    ld(8'h01, 8'h08, 8'h03, 8'h08, 8'h00, 3'b000, 8'h02);
    ld(8'h02, 8'h88, 8'h10, 8'h08, 8'h00, 3'b000, 8'h03);
    ld(8'h03, 8'h70, 8'h10, 8'h08, 8'h08, 3'b000, 8'h04);
    ld(8'h04, 8'hE0, 8'h00, 8'h08, 8'h08, 3'b000, 8'h04);
    run_prog(3, 16, 8'h03, 8'h08, 8'h00, 3'b000);

    // Carry into zero, JMP !Z not taken
    do_reset();
    clear_imem();
    ld(8'h00, 8'h48, 8'hFF, 8'hFF, 8'h00, 3'b100, 8'h01);
    ld(8'h01, 8'h08, 8'h01, 8'h00, 8'h00, 3'b011, 8'h02);
    ld(8'h02, 8'hC2, 8'h20, 8'h00, 8'h00, 3'b011, 8'h03);
    ld(8'h03, 8'hE0, 8'h00, 8'h00, 8'h00, 3'b011, 8'h03);
    run_prog(0, 8, 8'h00, 8'h00, 8'h00, 3'b000);
    chk("p3_fault", 32'(fault), 32'd0);

    // JMP Z taken, full ALU sweep, conditional jumps, DM[B], undefined fn
    do_reset();
    clear_imem();
    ld(8'h00, 8'h48, 8'hFF, 8'hFF, 8'h00, 3'b100, 8'h01);
    ld(8'h01, 8'h08, 8'h01, 8'h00, 8'h00, 3'b011, 8'h02);
    ld(8'h02, 8'hC1, 8'h20, 8'h00, 8'h00, 3'b011, 8'h20);
    ld(8'h20, 8'h68, 8'h03, 8'h00, 8'h03, 3'b000, 8'h21);
    ld(8'h21, 8'h09, 8'h05, 8'hFB, 8'h03, 3'b101, 8'h22);
    ld(8'h22, 8'h0A, 8'h0F, 8'h0B, 8'h03, 3'b000, 8'h23);
    ld(8'h23, 8'h0B, 8'hF0, 8'hFB, 8'h03, 3'b100, 8'h24);
    ld(8'h24, 8'h0C, 8'hFF, 8'h04, 8'h03, 3'b000, 8'h25);
    ld(8'h25, 8'h0D, 8'h0F, 8'hF0, 8'h03, 3'b100, 8'h26);
    ld(8'h26, 8'h0E, 8'h81, 8'h02, 8'h03, 3'b001, 8'h27);
    ld(8'h27, 8'h0F, 8'h03, 8'h01, 8'h03, 3'b001, 8'h28);
    ld(8'h28, 8'h00, 8'h00, 8'h04, 8'h03, 3'b000, 8'h29);
    ld(8'h29, 8'h21, 8'h00, 8'h04, 8'hFF, 3'b101, 8'h2A);
    ld(8'h2A, 8'hC3, 8'h30, 8'h04, 8'hFF, 3'b101, 8'h30);
    ld(8'h30, 8'hA0, 8'h00, 8'h04, 8'hFF, 3'b101, 8'h31);
    ld(8'h31, 8'h18, 8'h00, 8'h03, 8'hFF, 3'b001, 8'h32);
    ld(8'h32, 8'hC4, 8'h40, 8'h03, 8'hFF, 3'b001, 8'h33);
    ld(8'h33, 8'hC2, 8'h40, 8'h03, 8'hFF, 3'b001, 8'h40);
    ld(8'h40, 8'h48, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h41);
    ld(8'h41, 8'hC7, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h42);
`ifdef CALL_STACK_EN
    ld(8'h42, 8'hC5, 8'h50, 8'h00, 8'hFF, 3'b010, 8'h50);
    ld(8'h50, 8'hC6, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h43);
    ld(8'h43, 8'hC6, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h43);
    run_prog(0, 46, 8'h00, 8'h00, 8'h00, 3'b000);
    chk("p2_fault", 32'(fault), 32'd1);
    chk("p2_fault_pc", 32'(imem_addr), 32'h43);
`else
    ld(8'h42, 8'hC5, 8'h50, 8'h00, 8'hFF, 3'b010, 8'h43);
    ld(8'h43, 8'hC6, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h44);
    ld(8'h44, 8'hE0, 8'h00, 8'h00, 8'hFF, 3'b010, 8'h44);
    run_prog(0, 46, 8'h00, 8'h00, 8'h00, 3'b000);
    chk("p2_fault", 32'(fault), 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // 4-bit PC: JMP 15; MOVA #7 at 15 wraps PC to 0
    imem4[0]  = {8'hC0, 8'h0F};
    imem4[15] = {8'h48, 8'h07};
    do_reset4();
    chk("w_rst_pc", 32'(imem4_addr), 32'd0);
    run4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w_alu_exec", 32'(alu4), 32'h07);
    @(posedge clk);
    @(negedge clk);
    chk("w_a", 32'(a4), 32'h07);
    chk("w_pc_wrap", 32'(imem4_addr), 32'd0);
    run4 = 1'b0;

    // Reset during EXEC of a store must not write DM
    imem4[0] = {8'h48, 8'h11};
    imem4[1] = {8'h88, 8'h03};
    imem4[2] = {8'h48, 8'h22};
    imem4[3] = {8'h88, 8'h03};
    do_reset4();
    run4 = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("s_a_before", 32'(a4), 32'h22);
    chk("s_pc_exec", 32'(imem4_addr), 32'h3);
    rst4_n = 1'b0;
    run4   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem4[0] = {8'h70, 8'h03};
    imem4[1] = 16'hE000;
    rst4_n = 1'b1;
    chk("s_a_reset", 32'(a4), 32'd0);
    run4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("s_dm_kept", 32'(b4), 32'h11);
    run4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
